// File: rtl/bin2dec_text_seq.sv
// Multi-cycle binary-to-ASCII decimal converter (double-dabble) feeding the text renderer.
// Produces a sign byte followed by DIGITS decimal characters, MSB first, held between conversions.
module bin2dec_text_seq #(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 10,
  parameter int LZ_BLANK = 0
) (
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           value,
  input  logic                       is_signed,
  output logic                       busy,
  output logic                       done,
  output logic [0:(DIGITS+1)*8-1]    text
);

  localparam int BW = DIGITS * 4;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = (DIGITS + 1) * 8;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FORMAT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] val_q;
  logic             sgn_q;
  logic             neg_q;
  logic [WIDTH-1:0] mag_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_adj;
  logic [CW-1:0]    cnt_q;
  logic [0:TW-1]    text_fmt;
  logic             lead;
  logic [3:0]       nib;
  logic [3:0]       adj_nib;

  // Handshake: start is sampled only in IDLE; busy covers LOAD..FORMAT;
  // done pulses for one cycle on the same edge that updates text.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (cnt_q == '0) state_nx = FORMAT;
      FORMAT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    adj_nib = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj_nib = bcd_q[d*4 +: 4];
      if (adj_nib >= 4'd5) bcd_adj[d*4 +: 4] = adj_nib + 4'd3;
    end
  end

  // Leading-zero blanking never touches the last digit, so zero prints as "0".
  always_comb begin
    text_fmt = '0;
    lead     = 1'b1;
    nib      = '0;
    text_fmt[0 +: 8] = neg_q ? 8'h2D : 8'h20;
    for (int j = 1; j <= DIGITS; j++) begin
      nib = bcd_q[(DIGITS-j)*4 +: 4];
      if ((LZ_BLANK != 0) && lead && (nib == 4'd0) && (j != DIGITS)) begin
        text_fmt[j*8 +: 8] = 8'h20;
      end else begin
        text_fmt[j*8 +: 8] = {4'h3, nib};
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      val_q <= '0;
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
      text  <= {(DIGITS+1){8'h20}};
    end else begin
      done <= (state == FORMAT);
      case (state)
        IDLE: begin
          if (start) begin
            val_q <= value;
            sgn_q <= is_signed;
          end
        end
        LOAD: begin
          neg_q <= sgn_q & val_q[WIDTH-1];
          mag_q <= (sgn_q & val_q[WIDTH-1]) ? (~val_q) + WIDTH'(1) : val_q;
          bcd_q <= '0;
          cnt_q <= CW'(WIDTH - 1);
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
          mag_q <= {mag_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
        end
        FORMAT: begin
          text <= text_fmt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bin2dec_text_seq.md
Name: bin2dec_text_seq

Overview:
- Sequential binary-to-ASCII decimal converter using double-dabble (shift-and-add-3). Signed or unsigned values are supported.
- Sits directly upstream of the text renderer (autoMAN word input) in the VGA path. It replaces wide combinational divide/modulo chains with a multi-cycle converter.
- Takes a run-time data word (e.g. CPU VGA_data or an instruction immediate) and produces a fixed-width, sign-prefixed, MSB-first ASCII string. The string is held stable for the renderer between conversions.

Parameters:
- WIDTH, 32, bit width of the binary input.
- DIGITS, 10, number of decimal digits produced. Must be >= ceil(WIDTH*log10(2)); 10 for WIDTH=32, 5 for WIDTH=16.
- LZ_BLANK, 0, 1 = replace leading zeros with ASCII space (the least significant digit is never blanked); 0 = keep zeros.

Ports:
- vga_clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request a conversion; sampled only in IDLE.
- value  in  WIDTH  binary operand; captured on the accepted start.
- is_signed  in  1  1 = treat value as two's complement; captured with value.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when text is updated.
- text  out  (DIGITS+1)*8  declared [0:(DIGITS+1)*8-1]. Byte 0 = sign character; bytes 1..DIGITS = digits, most significant first.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, text = all bytes 8'h20 (space), internal BCD/shift registers = 0.
- FSM states: IDLE, LOAD, SHIFT, FORMAT.
- IDLE:
  - start=1 at edge k -> capture value and is_signed, go to LOAD; busy=1 from k+1.
  - start=0 -> stay in IDLE.
- LOAD (1 cycle):
  - neg = is_signed & value[WIDTH-1].
  - mag = neg ? (~value + 1) : value, computed in WIDTH bits, unsigned. The most negative value maps to 2^(WIDTH-1) with no overflow.
  - BCD = 0; shift counter = WIDTH-1; go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - Each cycle, every 4-bit BCD nibble >= 5 gets +3 first; then {BCD, mag} shifts left by 1.
  - Counter decrements; after the cycle where the counter is 0, go to FORMAT.
- FORMAT (1 cycle):
  - text[0:7] = neg ? "-" : " ".
  - Digit byte i = 8'h30 + nibble, MSB digit first.
  - If LZ_BLANK=1, leading zero digits become 8'h20, except the last digit. The sign stays at byte 0 and is not moved next to the number.
  - done=1 for this one cycle; busy=0 from the next cycle; return to IDLE.
- Latency: start accepted at edge k -> text updated and done=1 after edge k+WIDTH+2 (34 cycles for WIDTH=32). Throughput is one conversion per WIDTH+3 cycles when start is held high.
- text changes only on the FORMAT edge, so the consumer never sees partial digits. Otherwise text holds its last value indefinitely.
- Start while busy (LOAD/SHIFT/FORMAT): ignored; not queued. The value/is_signed captured at accept are unaffected by later input changes.
- Start high in the cycle after done (IDLE again): accepted normally.
- Reset mid-conversion: aborts immediately; no done pulse; text returns to spaces.
- is_signed=0 with value[MSB]=1: shown as a positive unsigned number, sign byte " ".
- Any BCD carry beyond DIGITS is a parameter error (not checked at run time).

Test Plan:
- Reset, then start with value=12345, is_signed=0 -> busy rises 1 cycle after accept; done exactly 34 cycles after accept; text=" 0000012345".
- value=32'hFFFFFFFF: with is_signed=1 -> "-0000000001"; with is_signed=0 -> " 4294967295".
- value=32'h80000000: with is_signed=1 -> "-2147483648"; with is_signed=0 -> " 2147483648". value=0 -> " 0000000000".
- LZ_BLANK=1: value=7 unsigned -> "          7"; value=-7 signed -> "-         7"; value=0 -> "          0".
- Start value=99, then pulse start with value=5 at cycle +10 while busy, and change value mid-run -> only one done pulse; text=" 0000000099"; second start ignored.
- Start value=123, assert reset at cycle +15 -> busy=0, done never pulses, text = 11 spaces. After reset release, start value=42 -> " 0000000042" with normal latency.
- WIDTH=16, DIGITS=5: value=16'hFFF6 signed -> "-00010", done 18 cycles after accept.
